// File: rtl/vector_decode_issue_pkg.sv
// Shared types for the vector decode/issue front end: opcodes, uop layout,
// format classification and the word-to-uop unpacking helper.
package vector_decode_issue_pkg;

   localparam int VIDX_W = 8;

   localparam logic [6:0] VOP_ADD  = 7'h10;
   localparam logic [6:0] VOP_SUB  = 7'h11;
   localparam logic [6:0] VOP_ADDI = 7'h20;
   localparam logic [6:0] VOP_SUBI = 7'h21;
   localparam logic [6:0] VOP_VLD  = 7'h40;
   localparam logic [6:0] VOP_VST  = 7'h41;

   typedef enum logic [5:0] {
      VALU_ADD = 6'h00,
      VALU_SUB = 6'h01
   } valu_op_t;

   typedef enum logic [1:0] {FMT_R, FMT_I, FMT_M, FMT_ILL} fmt_t;

   typedef enum logic {UNIT_ALU = 1'b0, UNIT_MEM = 1'b1} unit_t;

   typedef logic [VIDX_W-1:0] vidx_t;

   typedef struct packed {
      unit_t      unit;
      valu_op_t   op;
      vidx_t      vd;
      vidx_t      vs1;
      vidx_t      vs2;
      logic [7:0] imm;
      logic       use_imm;
      logic       mask;
      logic       store;
      logic [7:0] rs1;
      logic       sp;
      logic       transpose;
      logic       swizzle;
      logic [1:0] dtype;
   } vuop_t;

   // The [6:0] opcode match wins over the M-type [9:3] field.
   function automatic fmt_t get_fmt(input logic [31:0] instr);
      if (instr[6:0] == VOP_ADD || instr[6:0] == VOP_SUB)   return FMT_R;
      if (instr[6:0] == VOP_ADDI || instr[6:0] == VOP_SUBI) return FMT_I;
      if (instr[9:3] == VOP_VLD || instr[9:3] == VOP_VST)   return FMT_M;
      return FMT_ILL;
   endfunction

   function automatic vuop_t decode_instr(input logic [31:0] instr);
      vuop_t u;
      fmt_t  f;
      f = get_fmt(instr);
      u = '0;
      case (f)
         FMT_R, FMT_I: begin
            u.unit = UNIT_ALU;
            u.op   = (instr[6:0] == VOP_SUB || instr[6:0] == VOP_SUBI) ? VALU_SUB : VALU_ADD;
            u.mask = instr[31];
            u.vd   = instr[30:23];
            u.vs1  = instr[22:15];
            if (f == FMT_R) begin
               u.vs2 = instr[14:7];
            end else begin
               u.imm     = instr[14:7];
               u.use_imm = 1'b1;
            end
         end
         FMT_M: begin
            u.unit      = UNIT_MEM;
            u.swizzle   = instr[31];
            u.transpose = instr[30];
            u.dtype     = instr[29:28];
            u.vd        = instr[27:20];
            u.mask      = instr[19];
            u.rs1       = instr[18:11];
            u.sp        = instr[10];
            u.store     = (instr[9:3] == VOP_VST);
         end
         default: ;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/vector_decode_issue_if.sv
// Handshake bundle between fetch/dispatch, the decoder and the vector units.
// master = the side driving instructions, readies and writebacks.
interface vector_decode_issue_if
   import vector_decode_issue_pkg::*;
#(
   parameter int ILL_CNT_W = 16
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_instr;
   logic                 flush;

   logic                 valu_valid;
   logic                 valu_ready;
   valu_op_t             valu_op;
   logic [7:0]           valu_vd;
   logic [7:0]           valu_vs1;
   logic [7:0]           valu_vs2;
   logic [7:0]           valu_imm;
   logic                 valu_use_imm;
   logic                 valu_mask;

   logic                 vmem_valid;
   logic                 vmem_ready;
   logic                 vmem_store;
   logic [7:0]           vmem_vd;
   logic [7:0]           vmem_rs1;
   logic                 vmem_sp;
   logic                 vmem_mask;
   logic                 vmem_transpose;
   logic                 vmem_swizzle;
   logic [1:0]           vmem_dtype;

   logic                 wb_valid;
   logic [7:0]           wb_vd;

   logic                 illegal;
   logic [ILL_CNT_W-1:0] illegal_cnt;

   modport master (
      output in_valid, in_instr, flush, valu_ready, vmem_ready, wb_valid, wb_vd,
      input  in_ready, valu_valid, valu_op, valu_vd, valu_vs1, valu_vs2, valu_imm,
             valu_use_imm, valu_mask, vmem_valid, vmem_store, vmem_vd, vmem_rs1,
             vmem_sp, vmem_mask, vmem_transpose, vmem_swizzle, vmem_dtype,
             illegal, illegal_cnt
   );

   modport slave (
      input  in_valid, in_instr, flush, valu_ready, vmem_ready, wb_valid, wb_vd,
      output in_ready, valu_valid, valu_op, valu_vd, valu_vs1, valu_vs2, valu_imm,
             valu_use_imm, valu_mask, vmem_valid, vmem_store, vmem_vd, vmem_rs1,
             vmem_sp, vmem_mask, vmem_transpose, vmem_swizzle, vmem_dtype,
             illegal, illegal_cnt
   );
endinterface

// File: rtl/vector_decode_issue_scoreboard.sv
// Vector-register pending bits: set on issue, cleared on writeback, three
// combinational read ports for the hazard check.
module vector_decode_issue_scoreboard #(
   parameter int NUM_VREGS = 256,
   parameter int IDX_W     = $clog2(NUM_VREGS)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             set_en,
   input  logic [IDX_W-1:0] set_idx,
   input  logic             clr_en,
   input  logic [IDX_W-1:0] clr_idx,
   input  logic [IDX_W-1:0] vs1_idx,
   input  logic [IDX_W-1:0] vs2_idx,
   input  logic [IDX_W-1:0] vd_idx,
   output logic             vs1_pend,
   output logic             vs2_pend,
   output logic             vd_pend
);
   logic [NUM_VREGS-1:0] pending_q;

   // Track outstanding writes; the set follows the clear so it wins on a tie.
   always_ff @(posedge CLK) begin
      // NOTE: pending is a flop array, not RAM, so it is cleared wholesale on
      // reset; leaving it uninitialised would block issue on random registers.
      if (RST) begin
         pending_q <= '0;
      end else begin
         if (clr_en) pending_q[clr_idx] <= 1'b0;
         if (set_en) pending_q[set_idx] <= 1'b1;
      end
   end

   assign vs1_pend = pending_q[vs1_idx];
   assign vs2_pend = pending_q[vs2_idx];
   assign vd_pend  = pending_q[vd_idx];

endmodule

// File: rtl/vector_decode_issue.sv
// Vector decode/issue: accepts instruction words, unpacks them into a single
// decode register and issues to the ALU or memory unit once hazard-free.
module vector_decode_issue
   import vector_decode_issue_pkg::*;
#(
   parameter int NUM_VREGS = 256,
   parameter int ILL_CNT_W = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   vector_decode_issue_if.slave bus
);
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   logic [0:0]           state_q;
   vuop_t                dr_q;
   logic                 illegal_q;
   logic [ILL_CNT_W-1:0] ill_cnt_q;

   fmt_t  dec_fmt;
   vuop_t dec_uop;
   logic  pend_vs1, pend_vs2, pend_vd;
   logic  hazard, issue_ok, alu_valid, mem_valid, fire;
   logic  accept, accept_ok, accept_ill, sb_set;

   assign dec_fmt = get_fmt(bus.in_instr);
   assign dec_uop = decode_instr(bus.in_instr);

   // Hazard check against registered pending bits and issue handshake.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned
      // and infers a latch.
      hazard    = pend_vd;
      issue_ok  = 1'b0;
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      if (dr_q.unit == UNIT_ALU) begin
         hazard = pend_vd || pend_vs1 || (!dr_q.use_imm && pend_vs2);
      end
      issue_ok  = (state_q == ST_HOLD) && !hazard && !bus.flush && !RST;
      alu_valid = issue_ok && (dr_q.unit == UNIT_ALU);
      mem_valid = issue_ok && (dr_q.unit == UNIT_MEM);
   end

   assign fire       = (alu_valid && bus.valu_ready) || (mem_valid && bus.vmem_ready);
   assign bus.in_ready = (state_q == ST_EMPTY) || fire || bus.flush;
   assign accept     = bus.in_valid && bus.in_ready;
   assign accept_ok  = accept && (dec_fmt != FMT_ILL);
   assign accept_ill = accept && (dec_fmt == FMT_ILL);
   assign sb_set     = fire && !((dr_q.unit == UNIT_MEM) && dr_q.store);

   // Decode register: refill on accept, otherwise drain on fire or flush.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (RST) begin
         state_q <= ST_EMPTY;
         dr_q    <= '0;
      end else if (accept_ok) begin
         state_q <= ST_HOLD;
         dr_q    <= dec_uop;
      end else if (fire || bus.flush) begin
         state_q <= ST_EMPTY;
      end
   end

   // Illegal-word pulse and saturating counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         illegal_q <= 1'b0;
         ill_cnt_q <= '0;
      end else begin
         illegal_q <= accept_ill;
         if (accept_ill && (ill_cnt_q != '1)) ill_cnt_q <= ill_cnt_q + 1'b1;
      end
   end

   vector_decode_issue_scoreboard #(.NUM_VREGS(NUM_VREGS)) u_sb (
      .CLK      (CLK),
      .RST      (RST),
      .set_en   (sb_set),
      .set_idx  (dr_q.vd),
      .clr_en   (bus.wb_valid),
      .clr_idx  (bus.wb_vd),
      .vs1_idx  (dr_q.vs1),
      .vs2_idx  (dr_q.vs2),
      .vd_idx   (dr_q.vd),
      .vs1_pend (pend_vs1),
      .vs2_pend (pend_vs2),
      .vd_pend  (pend_vd)
   );

   assign bus.valu_valid     = alu_valid;
   assign bus.valu_op        = dr_q.op;
   assign bus.valu_vd        = dr_q.vd;
   assign bus.valu_vs1       = dr_q.vs1;
   assign bus.valu_vs2       = dr_q.vs2;
   assign bus.valu_imm       = dr_q.imm;
   assign bus.valu_use_imm   = dr_q.use_imm;
   assign bus.valu_mask      = dr_q.mask;

   assign bus.vmem_valid     = mem_valid;
   assign bus.vmem_store     = dr_q.store;
   assign bus.vmem_vd        = dr_q.vd;
   assign bus.vmem_rs1       = dr_q.rs1;
   assign bus.vmem_sp        = dr_q.sp;
   assign bus.vmem_mask      = dr_q.mask;
   assign bus.vmem_transpose = dr_q.transpose;
   assign bus.vmem_swizzle   = dr_q.swizzle;
   assign bus.vmem_dtype     = dr_q.dtype;

   assign bus.illegal        = illegal_q;
   assign bus.illegal_cnt    = ill_cnt_q;

endmodule

// File: tb/tb_vector_decode_issue.sv
// Directed bench for vector_decode_issue: expected issues are queued as words
// are driven and compared when the DUT fires a handshake.
module tb_vector_decode_issue;

   logic clk;
   logic rst;

   vector_decode_issue_if bus ();

   vector_decode_issue dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic       mem;
      logic [5:0] op;
      logic [7:0] vd;
      logic [7:0] vs1;
      logic [7:0] vs2;
      logic [7:0] imm;
      logic       use_imm;
      logic       mask;
      logic       store;
      logic [7:0] rs1;
      logic       sp;
      logic       transpose;
      logic       swizzle;
      logic [1:0] dtype;
   } exp_t;

   localparam logic [6:0] OP_ADD  = 7'h10;
   localparam logic [6:0] OP_SUB  = 7'h11;
   localparam logic [6:0] OP_ADDI = 7'h20;
   localparam logic [6:0] OP_SUBI = 7'h21;
   localparam logic [6:0] OP_VLD  = 7'h40;
   localparam logic [6:0] OP_VST  = 7'h41;

   int   n_vec    = 0;
   int   n_bad    = 0;
   int   n_issued = 0;
   exp_t exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_ri(input logic [6:0] op, input logic mask,
                                          input logic [7:0] vd, vs1, vs2_imm);
      return {mask, vd, vs1, vs2_imm, op};
   endfunction

   function automatic logic [31:0] enc_m(input logic [6:0] op, input logic swz, tr,
                                         input logic [1:0] dt, input logic [7:0] vd,
                                         input logic mask, input logic [7:0] rs1,
                                         input logic sp);
      return {swz, tr, dt, vd, mask, rs1, sp, op, 3'b000};
   endfunction

   function automatic exp_t exp_alu(input logic [5:0] op, input logic [7:0] vd, vs1, vs2, imm,
                                    input logic use_imm, mask);
      exp_t e = '0;
      e.op = op; e.vd = vd; e.vs1 = vs1; e.vs2 = vs2; e.imm = imm;
      e.use_imm = use_imm; e.mask = mask;
      return e;
   endfunction

   function automatic exp_t exp_mem(input logic store, input logic [7:0] vd, rs1,
                                    input logic mask, sp, tr, swz, input logic [1:0] dt);
      exp_t e = '0;
      e.mem = 1'b1; e.store = store; e.vd = vd; e.rs1 = rs1; e.mask = mask;
      e.sp = sp; e.transpose = tr; e.swizzle = swz; e.dtype = dt;
      return e;
   endfunction

   function automatic exp_t obs_alu();
      exp_t e = '0;
      e.op = bus.valu_op; e.vd = bus.valu_vd; e.vs1 = bus.valu_vs1; e.vs2 = bus.valu_vs2;
      e.imm = bus.valu_imm; e.use_imm = bus.valu_use_imm; e.mask = bus.valu_mask;
      return e;
   endfunction

   function automatic exp_t obs_mem();
      exp_t e = '0;
      e.mem = 1'b1; e.store = bus.vmem_store; e.vd = bus.vmem_vd; e.rs1 = bus.vmem_rs1;
      e.mask = bus.vmem_mask; e.sp = bus.vmem_sp; e.transpose = bus.vmem_transpose;
      e.swizzle = bus.vmem_swizzle; e.dtype = bus.vmem_dtype;
      return e;
   endfunction

   // Issue monitor: sampled mid-cycle, a fire happens at the coming edge.
   always @(negedge clk) begin
      exp_t e;
      if (bus.valu_valid && bus.valu_ready) begin
         n_issued++;
         if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
         check("alu_issue", 64'(obs_alu()), 64'(e));
      end
      if (bus.vmem_valid && bus.vmem_ready) begin
         n_issued++;
         if (exp_q.size() != 0) e = exp_q.pop_front(); else e = 'x;
         check("mem_issue", 64'(obs_mem()), 64'(e));
      end
   end

   // Present a word from posedge+1 until accepted, bounded.
   task automatic send(input logic [31:0] w, output int waits);
      waits = 0;
      bus.in_valid = 1'b1;
      bus.in_instr = w;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         waits++;
         if (waits >= 50) begin
            check("accept_timeout", 64'(waits), 64'(0));
            break;
         end
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete, vectors %0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      int   w;
      int   issued_snap;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.flush = 1'b0;
      bus.valu_ready = 1'b1; bus.vmem_ready = 1'b1;
      bus.wb_valid = 1'b0; bus.wb_vd = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
      check("rst_valids", 64'({bus.valu_valid, bus.vmem_valid, bus.illegal}), 64'(0));
      check("rst_ill_cnt", 64'(bus.illegal_cnt), 64'(0));
      check("rst_alu_fields", 64'(obs_alu()), 64'(exp_alu(0, 0, 0, 0, 0, 0, 0)));
      check("rst_mem_fields", 64'(obs_mem()), 64'(exp_mem(0, 0, 0, 0, 0, 0, 0, 0)));
      check("rst_pending", 64'(|dut.u_sb.pending_q), 64'(0));
      step();

      // ADD vd=3 vs1=1 vs2=2: valid the cycle after accept, pending[3] after fire.
      exp_q.push_back(exp_alu(6'h00, 8'd3, 8'd1, 8'd2, 8'd0, 1'b0, 1'b0));
      send(enc_ri(OP_ADD, 1'b0, 8'd3, 8'd1, 8'd2), w);
      @(negedge clk);
      check("add_valid_latency", 64'(bus.valu_valid), 64'(1'b1));
      step();
      check("add_pending3", 64'(dut.u_sb.pending_q[3]), 64'(1'b1));

      // ADD vd=5 then SUBI vd=6 vs1=5: back-to-back accept, RAW stall until wb.
      exp_q.push_back(exp_alu(6'h00, 8'd5, 8'd1, 8'd2, 8'd0, 1'b0, 1'b1));
      send(enc_ri(OP_ADD, 1'b1, 8'd5, 8'd1, 8'd2), w);
      exp_q.push_back(exp_alu(6'h01, 8'd6, 8'd5, 8'd0, 8'h7F, 1'b1, 1'b0));
      send(enc_ri(OP_SUBI, 1'b0, 8'd6, 8'd5, 8'h7F), w);
      check("subi_back_to_back_accept", 64'(w), 64'(0));
      repeat (4) begin
         @(negedge clk);
         check("subi_raw_stall", 64'(bus.valu_valid), 64'(0));
      end
      step();
      bus.wb_valid = 1'b1; bus.wb_vd = 8'd5;
      @(negedge clk);
      check("subi_no_wb_bypass", 64'(bus.valu_valid), 64'(0));
      step();
      bus.wb_valid = 1'b0;
      @(negedge clk);
      check("subi_issue_after_wb", 64'(bus.valu_valid), 64'(1'b1));
      step();

      // VLD vd=9 then VST vd=9: store waits for the load's writeback.
      exp_q.push_back(exp_mem(1'b0, 8'd9, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2));
      send(enc_m(OP_VLD, 1'b0, 1'b1, 2'd2, 8'd9, 1'b1, 8'h33, 1'b1), w);
      @(negedge clk);
      check("vld_valid", 64'({bus.vmem_valid, bus.vmem_store}), 64'(2'b10));
      step();
      check("vld_pending9", 64'(dut.u_sb.pending_q[9]), 64'(1'b1));
      exp_q.push_back(exp_mem(1'b1, 8'd9, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1));
      send(enc_m(OP_VST, 1'b1, 1'b0, 2'd1, 8'd9, 1'b0, 8'h0C, 1'b0), w);
      repeat (3) begin
         @(negedge clk);
         check("vst_stall", 64'(bus.vmem_valid), 64'(0));
      end
      step();
      bus.wb_valid = 1'b1; bus.wb_vd = 8'd9;
      step();
      bus.wb_valid = 1'b0;
      @(negedge clk);
      check("vst_issue_after_wb", 64'(bus.vmem_valid), 64'(1'b1));
      step();
      check("vst_sets_nothing", 64'(dut.u_sb.pending_q[9]), 64'(0));

      // Illegal word: pulse, count, no issue; then saturate the counter.
      issued_snap = n_issued;
      send(32'h0000_007F, w);
      @(negedge clk);
      check("ill_pulse", 64'(bus.illegal), 64'(1'b1));
      check("ill_cnt_1", 64'(bus.illegal_cnt), 64'(1));
      step();
      @(negedge clk);
      check("ill_pulse_one_cycle", 64'(bus.illegal), 64'(0));
      check("ill_no_issue", 64'(n_issued - issued_snap), 64'(0));
      step();
      bus.in_valid = 1'b1; bus.in_instr = 32'h0000_007F;
      repeat (65534) @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("ill_cnt_full", 64'(bus.illegal_cnt), 64'(16'hFFFF));
      step();
      send(32'h0000_007F, w);
      @(negedge clk);
      check("ill_cnt_saturate", 64'({bus.illegal, bus.illegal_cnt}), 64'({1'b1, 16'hFFFF}));
      step();

      // Backpressure: held ADD stays stable, then flush drops it.
      bus.valu_ready = 1'b0;
      send(enc_ri(OP_ADD, 1'b1, 8'd10, 8'd11, 8'd12), w);
      repeat (5) begin
         @(negedge clk);
         check("hold_valid", 64'({bus.valu_valid, bus.in_ready}), 64'(2'b10));
         check("hold_fields", 64'(obs_alu()),
               64'(exp_alu(6'h00, 8'd10, 8'd11, 8'd12, 8'd0, 1'b0, 1'b1)));
      end
      step();
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush_suppress", 64'(bus.valu_valid), 64'(0));
      step();
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush_dropped", 64'(bus.valu_valid), 64'(0));
      check("flush_pending", 64'({dut.u_sb.pending_q[3], dut.u_sb.pending_q[6],
                                  dut.u_sb.pending_q[10]}), 64'(3'b110));
      step();
      bus.valu_ready = 1'b1;

      // Writeback and issue of the same register in one cycle: set wins.
      exp_q.push_back(exp_alu(6'h01, 8'd4, 8'd1, 8'd2, 8'd0, 1'b0, 1'b0));
      send(enc_ri(OP_SUB, 1'b0, 8'd4, 8'd1, 8'd2), w);
      bus.wb_valid = 1'b1; bus.wb_vd = 8'd4;
      step();
      bus.wb_valid = 1'b0;
      check("set_wins_pending4", 64'(dut.u_sb.pending_q[4]), 64'(1'b1));

      // Reset mid-operation with a held uop and ready raised in the reset cycle.
      bus.valu_ready = 1'b0;
      send(enc_ri(OP_ADDI, 1'b0, 8'd30, 8'd31, 8'd1), w);
      rst = 1'b1; bus.valu_ready = 1'b1;
      @(negedge clk);
      check("rst_cycle_no_issue", 64'(bus.valu_valid), 64'(0));
      step();
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_clears", 64'({|dut.u_sb.pending_q, bus.valu_valid, bus.in_ready}),
            64'(3'b001));
      check("rst_mid_ill_cnt", 64'(bus.illegal_cnt), 64'(0));

      repeat (3) step();
      check("all_issued", 64'(exp_q.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
